doorlock_ctrl: RTL and testbench

//   Top-level sequencer for the doorlock datapath.

---
 rtl/doorlock_ctrl.sv | 151 +++++++++++++++
 tb/tb_doorlock_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/doorlock_ctrl.sv
// Doorlock sequencer: keypad/confirm strobes to datapath controls, unlock/lockout timers.
// Optional alarm output when DOORLOCK_ALARM_EN is defined.
module doorlock_ctrl #(
  parameter int OPEN_CYCLES  = 16,
  parameter int LOCK_CYCLES  = 64,
  parameter int MAX_FAILS    = 3,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       confirm,
  input  logic       long_confirm,
  input  logic       same,
  input  logic       master_same,
  input  logic       limit,
  output logic       input_v,
  output logic       decision,
  output logic       buff_rst,
  output logic       mem_rst,
  output logic       shuffle_init,
  output logic       unlock,
  output logic       lockout,
`ifdef DOORLOCK_ALARM_EN
  output logic       alarm,
`endif
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, MAUTH,
    MCHECK, REG_ENTRY, OPEN, LOCKOUT
  } state_t;

  localparam int TMAX0 =
    (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMAX =
    (TMAX0 > IDLE_TIMEOUT) ? TMAX0 : IDLE_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [1:0] MAXF = 2'(MAX_FAILS);

  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [1:0] fail_n, fail_inc;
  logic take_long, take_conf, take_key;
  logic entry_st, timed_out, key_ok, restart;

  assign take_long = long_confirm;
  assign take_conf = confirm & ~long_confirm;
  assign take_key  = key_press & ~confirm & ~long_confirm;
  assign timed_out = (timer == TW'(IDLE_TIMEOUT - 1));
  assign fail_inc  = (fail_cnt == MAXF) ? MAXF : fail_cnt + 2'd1;

  assign entry_st = (state == IDLE) || (state == ENTRY) ||
                    (state == MAUTH) || (state == REG_ENTRY);

  // Once the digit limit is hit, further digits must not overwrite the pw.
  assign key_ok = take_key && entry_st &&
                  !((state == REG_ENTRY) && limit);

  assign restart = (state_n != state) ||
                   ((take_key || take_conf) && entry_st);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      fail_cnt <= 2'd0;
      input_v  <= 1'b0;
    end else begin
      state    <= state_n;
      fail_cnt <= fail_n;
      input_v  <= key_ok;
      if (restart)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    fail_n  = fail_cnt;
    unique case (state)
      IDLE: begin
        if (take_long)     state_n = MAUTH;
        else if (take_key) state_n = ENTRY;
      end
      ENTRY: begin
        if (take_long)                 state_n = MAUTH;
        else if (take_conf)            state_n = CHECK;
        else if (!take_key && timed_out) state_n = IDLE;
      end
      CHECK: begin
        if (same && !limit) begin
          state_n = OPEN;
          fail_n  = 2'd0;
        end else begin
          fail_n  = fail_inc;
          state_n = (fail_inc == MAXF) ? LOCKOUT : IDLE;
        end
      end
      MAUTH: begin
        if (take_conf)                 state_n = MCHECK;
        else if (!take_key && timed_out) state_n = IDLE;
      end
      MCHECK: begin
        if (master_same) begin
          state_n = REG_ENTRY;
          fail_n  = 2'd0;
        end else begin
          fail_n  = fail_inc;
          state_n = (fail_inc == MAXF) ? LOCKOUT : IDLE;
        end
      end
      REG_ENTRY: begin
        if (take_conf)                 state_n = IDLE;
        else if (!take_key && timed_out) state_n = IDLE;
      end
      OPEN: begin
        if (timer == TW'(OPEN_CYCLES - 1)) state_n = IDLE;
      end
      LOCKOUT: begin
        if (timer == TW'(LOCK_CYCLES - 1)) begin
          state_n = IDLE;
          fail_n  = 2'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    decision     = (state == REG_ENTRY);
    unlock       = (state == OPEN);
    lockout      = (state == LOCKOUT);
    mem_rst      = (state == MCHECK) && master_same;
    shuffle_init = (state != IDLE) && (state_n == IDLE);
    buff_rst     = (state == CHECK) || (state == MCHECK) ||
                   (((state == IDLE) || (state == ENTRY)) && take_long) ||
                   (((state == ENTRY) || (state == MAUTH)) &&
                    (state_n == IDLE));
  end

`ifdef DOORLOCK_ALARM_EN
  assign alarm = (state == LOCKOUT) ||
                 ((fail_cnt == MAXF - 2'd1) && (fail_cnt != 2'd0) &&
                  (state != OPEN));
`endif

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed bench for doorlock_ctrl (default build, no alarm port).
// Inputs change 1ns after posedge; outputs are sampled before the next edge.
module tb_doorlock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_press = 0, confirm = 0, long_confirm = 0;
  logic same = 0, master_same = 0, limit = 0;
  logic input_v, decision, buff_rst, mem_rst, shuffle_init;
  logic unlock, lockout;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  doorlock_ctrl dut (
    .clk(clk), .rst(rst),
    .key_press(key_press), .confirm(confirm),
    .long_confirm(long_confirm), .same(same),
    .master_same(master_same), .limit(limit),
    .input_v(input_v), .decision(decision),
    .buff_rst(buff_rst), .mem_rst(mem_rst),
    .shuffle_init(shuffle_init), .unlock(unlock),
    .lockout(lockout), .fail_cnt(fail_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic key();
    key_press = 1; cyc(); key_press = 0;
  endtask

  task automatic wrong_code();
    key();
    same = 0; confirm = 1; cyc(); confirm = 0;
    cyc();
  endtask

  initial begin
    int cnt;
    int sh;
    int seen;

    // reset
    #3;
    chk("rst_unlock", unlock, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_buff", buff_rst, 0);
    chk("rst_iv", input_v, 0);
    cyc(); rst = 0;

    // 1: correct code opens for 16 cycles
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      key();
      cnt += input_v;
    end
    chk("t1_iv_pulses", cnt, 4);
    same = 1; limit = 0; confirm = 1; cyc(); confirm = 0;
    chk("t1_check_buff", buff_rst, 1);
    chk("t1_check_iv", input_v, 0);
    cyc();
    same = 0;
    cnt = 0; sh = 0; seen = 0;
    for (int i = 0; i < 40 && unlock; i++) begin
      cnt++;
      if (i == 4) key_press = 1;
      sh = shuffle_init;
      cyc();
      key_press = 0;
      seen |= input_v;
    end
    chk("t1_open_len", cnt, 16);
    chk("t1_shuffle", sh, 1);
    chk("t1_open_key_iv", seen, 0);

    // 2: three wrong codes -> lockout
    wrong_code();
    chk("t2_fail1", fail_cnt, 1);
    wrong_code();
    chk("t2_fail2", fail_cnt, 2);
    wrong_code();
    chk("t2_fail3", fail_cnt, 3);
    chk("t2_lockout", lockout, 1);
    cnt = 0; seen = 0;
    for (int i = 0; i < 200 && lockout; i++) begin
      cnt++;
      key_press = 1;
      cyc();
      key_press = 0;
      seen |= input_v;
    end
    chk("t2_lock_len", cnt, 64);
    chk("t2_lock_iv", seen, 0);
    chk("t2_fail_clr", fail_cnt, 0);

    // 3: master auth then register new pw
    long_confirm = 1; #1;
    chk("t3_long_buff", buff_rst, 1);
    cyc(); long_confirm = 0;
    key();
    chk("t3_m_iv", input_v, 1);
    chk("t3_m_dec", decision, 0);
    master_same = 1; confirm = 1; cyc(); confirm = 0;
    chk("t3_mem_rst", mem_rst, 1);
    chk("t3_mc_buff", buff_rst, 1);
    cyc(); master_same = 0;
    chk("t3_dec", decision, 1);
    key();
    chk("t3_reg_iv", input_v, 1);
    limit = 1;
    key();
    chk("t3_lim_iv", input_v, 0);
    limit = 0;
    confirm = 1; #1;
    chk("t3_shuffle", shuffle_init, 1);
    cyc(); confirm = 0;
    chk("t3_dec_clr", decision, 0);

    // 4: entry timeout, fail count preserved
    wrong_code();
    chk("t4_fail_pre", fail_cnt, 1);
    key();
    repeat (253) cyc();
    chk("t4_no_to", buff_rst, 0);
    cyc();
    chk("t4_to_buff", buff_rst, 1);
    chk("t4_to_shuf", shuffle_init, 1);
    cyc();
    chk("t4_fail_keep", fail_cnt, 1);
    chk("t4_no_unlock", unlock, 0);

    // 5: strobe precedence
    key();
    same = 0; confirm = 1; key_press = 1; cyc();
    confirm = 0; key_press = 0;
    chk("t5_check_buff", buff_rst, 1);
    chk("t5_no_iv", input_v, 0);
    cyc();
    chk("t5_fail2", fail_cnt, 2);
    key();
    long_confirm = 1; confirm = 1; #1;
    chk("t5_long_buff", buff_rst, 1);
    cyc(); long_confirm = 0; confirm = 0;
    chk("t5_mauth_buff", buff_rst, 0);
    master_same = 1; confirm = 1; cyc(); confirm = 0;
    chk("t5_mem_rst", mem_rst, 1);
    cyc(); master_same = 0;
    chk("t5_fail_clr", fail_cnt, 0);
    confirm = 1; cyc(); confirm = 0;

    // 6: async reset in OPEN and LOCKOUT
    key();
    same = 1; confirm = 1; cyc(); confirm = 0;
    cyc(); same = 0;
    repeat (3) cyc();
    chk("t6_open", unlock, 1);
    #2 rst = 1; #1;
    chk("t6_unlock_drop", unlock, 0);
    cyc(); rst = 0;
    wrong_code(); wrong_code(); wrong_code();
    repeat (5) cyc();
    chk("t6_locked", lockout, 1);
    #2 rst = 1; #1;
    chk("t6_lock_drop", lockout, 0);
    chk("t6_fail_rst", fail_cnt, 0);
    cyc(); rst = 0;
    key();
    chk("t6_idle_iv", input_v, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
